// File: rtl/seq_divider_pkg.sv
// Shared ALU package: divider FSM states, default datapath width and DIV/MOD opcodes.
package seq_divider_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Control unit raises start on either opcode; MOD selects remainder instead of quotient.
  localparam logic [1:0] OP_DIV = 2'b00;
  localparam logic [1:0] OP_MOD = 2'b01;

endpackage

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract,
// keep the difference when non-negative.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   rem,
  input  logic             quo_msb,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] diff;

  // rem[WIDTH] is always 0 between steps, so widening by one bit keeps the sign exact.
  assign sh       = {rem, quo_msb};
  assign diff     = sh - {2'b00, dvsr};
  assign q_bit    = ~diff[WIDTH+1];
  assign rem_next = q_bit ? diff[WIDTH:0] : sh[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with start/busy/done handshake.
// Define DIV_ZERO_DETECT_EN to enable the one-cycle divide-by-zero fast path.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [WIDTH:0]   rem_r, rem_step;
  logic [WIDTH-1:0] quo_r, dvsr_r;
  logic [CW-1:0]    cnt;
  logic             q_bit;
  logic             accept;
  logic             zero_fast;

  assign accept = (state == IDLE) && start;

`ifdef DIV_ZERO_DETECT_EN
  assign zero_fast = (divisor == '0);
`else
  assign zero_fast = 1'b0;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo_msb  (quo_r[WIDTH-1]),
    .dvsr     (dvsr_r),
    .rem_next (rem_step),
    .q_bit    (q_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assigned first so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = zero_fast ? DONE : RUN;
      RUN:     if (cnt == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_r     <= '0;
      quo_r     <= '0;
      dvsr_r    <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) begin
        quotient  <= quo_r;
        remainder <= rem_r[WIDTH-1:0];
      end
      // Accept wins over the clear so back-to-back operations keep busy high.
      if (accept)    busy <= 1'b1;
      else if (done) busy <= 1'b0;

      case (state)
        IDLE: if (start) begin
          dvsr_r <= divisor;
          cnt    <= CW'(WIDTH);
          if (zero_fast) begin
            rem_r <= {1'b0, dividend};
            quo_r <= '1;
          end else begin
            rem_r <= '0;
            quo_r <= dividend;
          end
        end
        RUN: begin
          rem_r <= rem_step;
          quo_r <= {quo_r[WIDTH-2:0], q_bit};
          cnt   <= cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  logic dz_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      dz_r     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (accept) dz_r <= zero_fast;
      if (state == DONE) div_zero <= dz_r;
    end
  end
`else
  assign div_zero = 1'b0;
`endif

endmodule
